// File: rtl/conv_filter_scheduler.sv
// rtl/conv_filter_scheduler.sv - sequences weight loads and conv runs across all filters of one layer
module conv_filter_scheduler #(
    parameter int DATA_W      = 16,
    parameter int WADDR_W     = 10,
    parameter int CADDR_W     = 4,
    parameter int KERNEL_SIZE = 9,
    parameter int NUM_FILTERS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [7:0]         filter_idx,
    output logic               wb_rd,
    output logic [WADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               cw_wr,
    output logic               cw_sel,
    output logic [CADDR_W-1:0] cw_addr,
    output logic [DATA_W-1:0]  cw_data,
    output logic               conv_start,
    input  logic               conv_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_START,
        S_WAIT,
        S_FIN
    } state_t;

    localparam logic [CADDR_W-1:0] K_LAST = CADDR_W'(KERNEL_SIZE - 1);
    localparam logic [7:0]         F_LAST = 8'(NUM_FILTERS - 1);
    localparam logic [WADDR_W-1:0] K_STEP = WADDR_W'(KERNEL_SIZE);

    state_t             r_state, w_state_nxt;
    logic [WADDR_W-1:0] r_base, w_base_nxt;
    logic [CADDR_W-1:0] r_k, w_k_nxt;
    logic [CADDR_W-1:0] w_k_inc;
    logic               r_drain, w_drain_nxt;
    logic [7:0]         r_fidx, w_fidx_nxt;

    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_wb_rd, w_rd_nxt;
    logic [WADDR_W-1:0] r_wb_addr, w_addr_nxt;
    logic               r_conv_start, w_cs_nxt;

    // Write side trails the read side by two cycles: one for BRAM latency, one for the data register
    logic               r_rd_d1;
    logic [CADDR_W-1:0] r_k_d1;
    logic               r_cw_wr;
    logic [CADDR_W-1:0] r_cw_addr;
    logic [DATA_W-1:0]  r_cw_data;

    assign w_k_inc = r_k + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_k_nxt     = r_k;
        w_drain_nxt = r_drain;
        w_fidx_nxt  = r_fidx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_rd_nxt    = 1'b0;
        w_addr_nxt  = r_wb_addr;
        w_cs_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_busy_nxt  = 1'b1;
                    w_base_nxt  = '0;
                    w_fidx_nxt  = '0;
                    w_k_nxt     = '0;
                    w_rd_nxt    = 1'b1;
                    w_addr_nxt  = '0;
                end
            end
            S_FETCH: begin
                if (r_k == K_LAST) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = 1'b0;
                end else begin
                    w_k_nxt    = w_k_inc;
                    w_rd_nxt   = 1'b1;
                    w_addr_nxt = r_base + WADDR_W'(w_k_inc);
                end
            end
            S_DRAIN: begin
                if (r_drain) begin
                    w_state_nxt = S_START;
                    w_cs_nxt    = 1'b1;
                end else begin
                    w_drain_nxt = 1'b1;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (conv_done) begin
                    if (r_fidx == F_LAST) begin
                        w_state_nxt = S_FIN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_fidx_nxt  = r_fidx + 8'd1;
                        w_base_nxt  = r_base + K_STEP;
                        w_k_nxt     = '0;
                        w_rd_nxt    = 1'b1;
                        w_addr_nxt  = r_base + K_STEP;
                    end
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_k          <= '0;
            r_drain      <= 1'b0;
            r_fidx       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wb_rd      <= 1'b0;
            r_wb_addr    <= '0;
            r_conv_start <= 1'b0;
            r_rd_d1      <= 1'b0;
            r_k_d1       <= '0;
            r_cw_wr      <= 1'b0;
            r_cw_addr    <= '0;
            r_cw_data    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_base       <= w_base_nxt;
            r_k          <= w_k_nxt;
            r_drain      <= w_drain_nxt;
            r_fidx       <= w_fidx_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_wb_rd      <= w_rd_nxt;
            r_wb_addr    <= w_addr_nxt;
            r_conv_start <= w_cs_nxt;
            r_rd_d1      <= r_wb_rd;
            r_k_d1       <= r_k;
            r_cw_wr      <= r_rd_d1;
            r_cw_addr    <= r_k_d1;
            if (r_rd_d1) begin
                r_cw_data <= wb_data;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign filter_idx = r_fidx;
    assign wb_rd      = r_wb_rd;
    assign wb_addr    = r_wb_addr;
    assign cw_wr      = r_cw_wr;
    assign cw_sel     = r_cw_wr;
    assign cw_addr    = r_cw_addr;
    assign cw_data    = r_cw_data;
    assign conv_start = r_conv_start;

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// tb/tb_conv_filter_scheduler.sv - randomized self-checking bench for conv_filter_scheduler
module tb_conv_filter_scheduler;

    localparam int K    = 9;
    localparam int NF_A = 4;
    localparam int AW_A = 10;
    localparam int NF_B = 2;
    localparam int AW_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      start, conv_done, busy, done, wb_rd, cw_wr, cw_sel, conv_start;
    logic [7:0]      fidx_a, fidx_b;
    logic [AW_A-1:0] wb_addr_a;
    logic [AW_B-1:0] wb_addr_b;
    logic [15:0]     wb_data_a, wb_data_b, cw_data_a, cw_data_b;
    logic [3:0]      cw_addr_a, cw_addr_b;
    logic [15:0]     mem [1024];
    int              errors = 0;
    int              checks = 0;

    conv_filter_scheduler #(
        .DATA_W(16), .WADDR_W(AW_A), .CADDR_W(4), .KERNEL_SIZE(K), .NUM_FILTERS(NF_A)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .filter_idx(fidx_a), .wb_rd(wb_rd[0]), .wb_addr(wb_addr_a), .wb_data(wb_data_a),
        .cw_wr(cw_wr[0]), .cw_sel(cw_sel[0]), .cw_addr(cw_addr_a), .cw_data(cw_data_a),
        .conv_start(conv_start[0]), .conv_done(conv_done[0])
    );

    conv_filter_scheduler #(
        .DATA_W(16), .WADDR_W(AW_B), .CADDR_W(4), .KERNEL_SIZE(K), .NUM_FILTERS(NF_B)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .filter_idx(fidx_b), .wb_rd(wb_rd[1]), .wb_addr(wb_addr_b), .wb_data(wb_data_b),
        .cw_wr(cw_wr[1]), .cw_sel(cw_sel[1]), .cw_addr(cw_addr_b), .cw_data(cw_data_b),
        .conv_start(conv_start[1]), .conv_done(conv_done[1])
    );

    always @(posedge clk) begin
        if (wb_rd[0]) wb_data_a <= mem[wb_addr_a];
        if (wb_rd[1]) wb_data_b <= mem[{6'd0, wb_addr_b}];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cycle(input string tag, input int inst, input bit all,
                                input int e_busy, input int e_done, input int e_fidx,
                                input int e_rd, input int e_addr, input int e_wr,
                                input int e_caddr, input int e_cdata, input int e_cs);
        logic [31:0] o_fidx, o_addr, o_caddr, o_cdata;
        o_fidx  = (inst == 0) ? fidx_a : fidx_b;
        o_addr  = (inst == 0) ? wb_addr_a : wb_addr_b;
        o_caddr = (inst == 0) ? cw_addr_a : cw_addr_b;
        o_cdata = (inst == 0) ? cw_data_a : cw_data_b;
        chk({tag, ".busy"}, busy[inst], e_busy);
        chk({tag, ".done"}, done[inst], e_done);
        chk({tag, ".filter_idx"}, o_fidx, e_fidx);
        chk({tag, ".wb_rd"}, wb_rd[inst], e_rd);
        if (all || e_rd != 0) chk({tag, ".wb_addr"}, o_addr, e_addr);
        chk({tag, ".cw_wr"}, cw_wr[inst], e_wr);
        chk({tag, ".cw_sel"}, cw_sel[inst], e_wr);
        if (all || e_wr != 0) begin
            chk({tag, ".cw_addr"}, o_caddr, e_caddr);
            chk({tag, ".cw_data"}, o_cdata, e_cdata);
        end
        chk({tag, ".conv_start"}, conv_start[inst], e_cs);
    endtask

    // Expected outputs at offset t after filter f begins fetching
    task automatic check_filter_cycle(input int inst, input int f, input int t, input int aw);
        int rd, wr, ra, wa, wd;
        rd = (t < K) ? 1 : 0;
        wr = (t >= 2 && t < K + 2) ? 1 : 0;
        ra = (f * K + t) % (1 << aw);
        wa = (wr != 0) ? (f * K + t - 2) % (1 << aw) : 0;
        wd = int'(mem[wa]);
        expect_cycle($sformatf("i%0d_f%0d_t%0d", inst, f, t), inst, 1'b0, 1, 0, f,
                     rd, ra, wr, t - 2, wd, (t == K + 2) ? 1 : 0);
    endtask

    task automatic run_layer(input int inst, input int nf, input int aw, input int first_gap,
                             input bit hold_start, input bit spurious, input int rst_t);
        int gap, dcyc;
        start[inst] = 1'b1;
        @(negedge clk);
        chk($sformatf("i%0d_idle.busy", inst), busy[inst], 0);
        @(posedge clk); #1;
        if (!hold_start) start[inst] = 1'b0;
        for (int f = 0; f < nf; f++) begin
            gap  = (f == 0 && first_gap > 0) ? first_gap : int'($urandom_range(1, 8));
            dcyc = K + 2 + gap;
            for (int t = 0; t <= dcyc; t++) begin
                conv_done[inst] = (t == dcyc) || (spurious && (t == 3 || t == K + 1 || t == K + 2));
                rst = (f == 1 && t == rst_t);
                @(negedge clk);
                check_filter_cycle(inst, f, t, aw);
                @(posedge clk); #1;
                if (rst) begin
                    rst = 1'b0;
                    conv_done[inst] = 1'b0;
                    start[inst] = 1'b0;
                    @(negedge clk);
                    expect_cycle($sformatf("i%0d_abort", inst), inst, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    @(posedge clk); #1;
                    return;
                end
            end
        end
        conv_done[inst] = 1'b0;
        @(negedge clk);
        expect_cycle($sformatf("i%0d_fin", inst), inst, 1'b0, 1, 1, nf - 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        start[inst] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            expect_cycle($sformatf("i%0d_post%0d", inst, i), inst, 1'b0, 0, 0, nf - 1, 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 2'b00;
        conv_done = 2'b00;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i + 1);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        expect_cycle("reset_a", 0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cycle("reset_b", 1, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Incrementing weights, first conv_done eight cycles after conv_start
        run_layer(0, NF_A, AW_A, 8, 1'b0, 1'b0, -1);

        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        run_layer(0, NF_A, AW_A, 0, 1'b1, 1'b0, -1);
        run_layer(0, NF_A, AW_A, 0, 1'b0, 1'b1, -1);
        run_layer(0, NF_A, AW_A, 0, 1'b0, 1'b0, 6);
        run_layer(0, NF_A, AW_A, 0, 1'b0, 1'b0, -1);

        // Narrow address space: filter 1 wraps past the top of the BRAM
        run_layer(1, NF_B, AW_B, 0, 1'b0, 1'b0, -1);
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        run_layer(1, NF_B, AW_B, 0, 1'b1, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
